// File: rtl/seq_alu.sv
// Clocked ALU: operand B and result share the tri-state data bus, shifts run one bit per cycle.
// Optional iterative multiply (op 8) is built only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ialu,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic             ealu,
  inout  wire  [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic             vf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [3:0] OP_SHL = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SEQ_ALU_MUL_EN
    , MUL = 2'd2
`endif
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] result_r, res_s;
  logic [WIDTH-1:0] sh_r, sh_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dir_r, dir_s;
  logic             zf_r, cf_r, nf_r, vf_r, err_r, err_s, done_r, busy_r;
  logic             wr_s, ill_s, cfv_s, vfv_s;

  logic [WIDTH-1:0] b_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v_s, sub_v_s;
  logic [CW-1:0]    k_s;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] acc_r, acc_s, mcd_r, mcd_s, mpl_r, mpl_s;
  logic [WIDTH:0]   mul_sum_s;
  assign mul_sum_s = {1'b0, acc_r} + (mpl_r[0] ? {1'b0, mcd_r} : {(WIDTH+1){1'b0}});
`endif

  // A chained accept (ealu and ialu together) takes B from the result register directly.
  assign b_s     = ealu ? result_r : data;
  assign add_s   = {1'b0, data_a} + {1'b0, b_s};
  assign sub_s   = {1'b0, data_a} - {1'b0, b_s};
  assign add_v_s = (data_a[WIDTH-1] == b_s[WIDTH-1]) && (add_s[WIDTH-1] != data_a[WIDTH-1]);
  assign sub_v_s = (data_a[WIDTH-1] != b_s[WIDTH-1]) && (sub_s[WIDTH-1] != data_a[WIDTH-1]);
  assign k_s     = (b_s >= WIDTH_V) ? CW'(WIDTH) : CW'(b_s);

  assign data = ealu ? result_r : {WIDTH{1'bz}};
  assign busy = busy_r;
  assign done = done_r;
  assign zf   = zf_r;
  assign cf   = cf_r;
  assign nf   = nf_r;
  assign vf   = vf_r;
  assign err  = err_r;

  // Next-state, iteration datapath and result/flag write selection.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    dir_s   = dir_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    wr_s    = 1'b0;
    ill_s   = 1'b0;
    res_s   = '0;
    cfv_s   = 1'b0;
    vfv_s   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    acc_s   = acc_r;
    mcd_s   = mcd_r;
    mpl_s   = mpl_r;
`endif
    case (state_r)
      IDLE: begin
        if (ialu) begin
          err_s = 1'b0;
          wr_s  = 1'b1;
          case (op)
            OP_ADD: begin res_s = add_s[WIDTH-1:0]; cfv_s = add_s[WIDTH]; vfv_s = add_v_s; end
            OP_SUB: begin res_s = sub_s[WIDTH-1:0]; cfv_s = sub_s[WIDTH]; vfv_s = sub_v_s; end
            OP_XOR: res_s = data_a ^ b_s;
            OP_OR:  res_s = data_a | b_s;
            OP_AND: res_s = data_a & b_s;
            OP_NOT: res_s = ~data_a;
            OP_SHL, OP_SHR: begin
              if (b_s == '0) begin
                res_s = data_a;
              end else begin
                wr_s    = 1'b0;
                state_s = SHIFT;
                sh_s    = data_a;
                dir_s   = (op == OP_SHR);
                cnt_s   = k_s;
              end
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
              wr_s    = 1'b0;
              state_s = MUL;
              acc_s   = '0;
              mcd_s   = data_a;
              mpl_s   = b_s;
              cnt_s   = CW'(WIDTH);
            end
`endif
            default: begin
              ill_s = 1'b1;
              err_s = 1'b1;
            end
          endcase
        end else begin
          wr_s = 1'b0;
        end
      end
      SHIFT: begin
        sh_s  = dir_r ? {1'b0, sh_r[WIDTH-1:1]} : {sh_r[WIDTH-2:0], 1'b0};
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          wr_s    = 1'b1;
          res_s   = sh_s;
          cfv_s   = dir_r ? sh_r[0] : sh_r[WIDTH-1];
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      MUL: begin
        acc_s = mul_sum_s[WIDTH:1];
        mpl_s = {mul_sum_s[0], mpl_r[WIDTH-1:1]};
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          wr_s    = 1'b1;
          res_s   = mpl_s;
          cfv_s   = |acc_s;
          state_s = IDLE;
        end else begin
          state_s = MUL;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State, working registers and registered outputs; an illegal op never raises zf.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      result_r <= '0;
      sh_r     <= '0;
      cnt_r    <= '0;
      dir_r    <= 1'b0;
      zf_r     <= 1'b0;
      cf_r     <= 1'b0;
      nf_r     <= 1'b0;
      vf_r     <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc_r    <= '0;
      mcd_r    <= '0;
      mpl_r    <= '0;
`endif
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      err_r   <= err_s;
      done_r  <= wr_s;
      busy_r  <= (state_s != IDLE);
`ifdef SEQ_ALU_MUL_EN
      acc_r   <= acc_s;
      mcd_r   <= mcd_s;
      mpl_r   <= mpl_s;
`endif
      if (wr_s) begin
        result_r <= res_s;
        zf_r     <= ~ill_s & (res_s == '0);
        nf_r     <= res_s[WIDTH-1];
        cf_r     <= cfv_s;
        vf_r     <= vfv_s;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=16) plus hand sequences for the iterative ops.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ialu = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] data_a = 16'h0000;
  logic        ealu = 1'b0;
  logic        busy, done, zf, cf, nf, vf, err;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_b = 16'h0000;
  wire  [15:0] data;

  int errors = 0;
  int checks = 0;

  assign data = tb_drv ? tb_b : 16'hzzzz;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ialu(ialu), .op(op), .data_a(data_a), .ealu(ealu),
    .data(data), .busy(busy), .done(done), .zf(zf), .cf(cf), .nf(nf), .vf(vf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;   // {zf, cf, nf, vf, err}
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_result(output logic [15:0] r);
    tb_drv = 1'b0;
    ealu   = 1'b1;
    #1;
    r    = data;
    ealu = 1'b0;
    #1;
  endtask

  task automatic single_op(input string name, input logic [3:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res, input logic [4:0] fl);
    logic [15:0] r;
    op = o; data_a = a; tb_b = b; tb_drv = 1'b1; ialu = 1'b1;
    @(posedge clk); #1;
    ialu = 1'b0;
    read_result(r);
    chk({name, "_res"}, 32'(r), 32'(res));
    chk({name, "_flags"}, 32'({zf, cf, nf, vf, err}), 32'(fl));
    chk({name, "_done_busy"}, 32'({done, busy}), 32'(2'b10));
  endtask

  task automatic run_iter(input string name, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int k, input logic [15:0] prev,
                          input logic [15:0] res, input logic [4:0] fl, input bit inject);
    logic [15:0] r;
    int n;
    bit done_seen;
    op = o; data_a = a; tb_b = b; tb_drv = 1'b1; ialu = 1'b1;
    @(posedge clk); #1;
    ialu = 1'b0; tb_drv = 1'b0;
    chk({name, "_busy_start"}, 32'({busy, done}), 32'(2'b10));
    read_result(r);
    chk({name, "_hold"}, 32'(r), 32'(prev));
    n = 0;
    done_seen = 1'b0;
    while (busy && n < 200) begin
      n++;
      if (done) done_seen = 1'b1;
      if (inject && n == 2) begin
        op = 4'd1; data_a = 16'h1111; tb_b = 16'h1111; tb_drv = 1'b1; ialu = 1'b1;
      end
      @(posedge clk); #1;
      ialu = 1'b0; tb_drv = 1'b0;
    end
    chk({name, "_cycles"}, 32'(n), 32'(k));
    chk({name, "_done_in_busy"}, 32'(done_seen), 32'(0));
    chk({name, "_done_end"}, 32'({done, busy}), 32'(2'b10));
    read_result(r);
    chk({name, "_res"}, 32'(r), 32'(res));
    chk({name, "_flags"}, 32'({zf, cf, nf, vf, err}), 32'(fl));
    @(posedge clk); #1;
    chk({name, "_done_drop"}, 32'(done), 32'(0));
  endtask

  initial begin
    logic [15:0] r;
    bit any_done;

    vecs[0]  = '{4'd1, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110};
    vecs[1]  = '{4'd2, 16'h0003, 16'h0005, 16'hFFFE, 5'b01100};
    vecs[2]  = '{4'd1, 16'hFFFF, 16'h0001, 16'h0000, 5'b11000};
    vecs[3]  = '{4'd2, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010};
    vecs[4]  = '{4'd3, 16'hF0F0, 16'hFF00, 16'h0FF0, 5'b00000};
    vecs[5]  = '{4'd4, 16'h1200, 16'h0034, 16'h1234, 5'b00000};
    vecs[6]  = '{4'd5, 16'hF0F0, 16'h0F0F, 16'h0000, 5'b10000};
    vecs[7]  = '{4'd7, 16'h00FF, 16'h0000, 16'hFF00, 5'b00100};
    vecs[8]  = '{4'd0, 16'h1234, 16'h0000, 16'h1234, 5'b00000};
    vecs[9]  = '{4'd6, 16'h8001, 16'h0000, 16'h8001, 5'b00100};
    vecs[10] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b00001};
    vecs[11] = '{4'd1, 16'h0002, 16'h0003, 16'h0005, 5'b00000};

    // reset state, bus drives zero while in reset with ealu=1
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_result(r);
    chk("reset_bus", 32'(r), 32'(0));
    chk("reset_outs", 32'({busy, done, zf, cf, nf, vf, err}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back single-cycle accepts
    for (int i = 0; i < 12; i++) begin
      single_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);
    end
    @(posedge clk); #1;
    chk("idle_done_low", 32'(done), 32'(0));
    read_result(r);
    chk("idle_hold", 32'(r), 32'h0005);

    // bus released when ealu=0
    tb_b = 16'h5A5A; tb_drv = 1'b1; ealu = 1'b0;
    #1;
    chk("bus_release", 32'(data), 32'h5A5A);
    tb_drv = 1'b0;

    // chained: B taken from current result
    op = 4'd1; data_a = 16'h0001; ealu = 1'b1; ialu = 1'b1;
    @(posedge clk); #1;
    ialu = 1'b0; ealu = 1'b0;
    read_result(r);
    chk("chain_res", 32'(r), 32'h0006);
    chk("chain_done", 32'(done), 32'(1));

    run_iter("shl4", 4'd0, 16'h8001, 16'h0004, 4, 16'h0006, 16'h0010, 5'b00000, 1'b1);
    run_iter("shr20", 4'd6, 16'h8000, 16'd20, 16, 16'h0010, 16'h0000, 5'b11000, 1'b0);
`ifdef SEQ_ALU_MUL_EN
    run_iter("mul", 4'd8, 16'h0100, 16'h0100, 16, 16'h0000, 16'h0000, 5'b11000, 1'b0);
    run_iter("mul2", 4'd8, 16'h0003, 16'hFFFF, 16, 16'h0000, 16'hFFFD, 5'b01100, 1'b0);
`else
    single_op("mul_ill", 4'd8, 16'h0100, 16'h0100, 16'h0000, 5'b00001);
`endif

    // reset in cycle 3 of a shift by 8 aborts it
    single_op("pre_rst", 4'd4, 16'h1200, 16'h0034, 16'h1234, 5'b00000);
    op = 4'd0; data_a = 16'h00FF; tb_b = 16'h0008; tb_drv = 1'b1; ialu = 1'b1;
    @(posedge clk); #1;
    ialu = 1'b0; tb_drv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    read_result(r);
    chk("rst_mid_bus", 32'(r), 32'(0));
    chk("rst_mid_outs", 32'({busy, done, zf, cf, nf, vf, err}), 32'(0));
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) any_done = 1'b1;
    end
    chk("rst_no_done", 32'(any_done), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
